fetch_unit: RTL and testbench

//  Instruction fetch front end. Generates sequential word addresses on the

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: control inputs, instruction-memory port and decode handshake.
// FETCH_MISALIGN_EN adds the INST_MISALIGN flag alongside the decode outputs.
interface fetch_unit_if;
    logic        FETCH_EN;
    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic        I_MEM_VALID;
    logic [31:0] I_MEM_ADDR;
    logic [3:0]  I_MEM_WSTB;
    logic [31:0] I_MEM_WDATA;
    logic        I_MEM_READY;
    logic [31:0] I_MEM_RDATA;
    logic        INST_VALID;
    logic        INST_READY;
    logic [31:0] INST_DATA;
    logic [31:0] INST_PC;
`ifdef FETCH_MISALIGN_EN
    logic        INST_MISALIGN;
`endif

    modport master (
        input  FETCH_EN, REDIRECT_VALID, REDIRECT_PC, I_MEM_READY, I_MEM_RDATA, INST_READY,
        output I_MEM_VALID, I_MEM_ADDR, I_MEM_WSTB, I_MEM_WDATA, INST_VALID, INST_DATA, INST_PC
`ifdef FETCH_MISALIGN_EN
        , output INST_MISALIGN
`endif
    );

    modport slave (
        output FETCH_EN, REDIRECT_VALID, REDIRECT_PC, I_MEM_READY, I_MEM_RDATA, INST_READY,
        input  I_MEM_VALID, I_MEM_ADDR, I_MEM_WSTB, I_MEM_WDATA, INST_VALID, INST_DATA, INST_PC
`ifdef FETCH_MISALIGN_EN
        , input INST_MISALIGN
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential issue, PC-tagged FIFO, redirect flush.
// FETCH_MISALIGN_EN adds a FAULT state that presents misaligned redirect targets to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic          CLK,
    input logic          RST_N,
    fetch_unit_if.master bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

`ifdef FETCH_MISALIGN_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_t;
`endif

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] discard_q, discard_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [31:0]   fifo_data_d [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d   [FIFO_DEPTH];
`ifdef FETCH_MISALIGN_EN
    logic          fifo_mis_q  [FIFO_DEPTH];
    logic          fifo_mis_d  [FIFO_DEPTH];
    logic          redir_mis;
`endif

    logic        ready_eff;
    logic        issue;
    logic        push;
    logic        pop;
    logic [31:0] redir_pc;

    always_comb begin
        // READY with nothing outstanding is a protocol error and is ignored
        ready_eff = bus.I_MEM_READY && (outst_q != '0);
        push      = ready_eff && (discard_q == '0);
        pop       = (count_q != '0) && bus.INST_READY;
        issue     = (state_q == ST_RUN) && !bus.REDIRECT_VALID
                    && (32'(outst_q) < MAX_OUTSTANDING)
                    && ((32'(count_q) + 32'(outst_q)) < FIFO_DEPTH);
`ifdef FETCH_MISALIGN_EN
        redir_pc  = bus.REDIRECT_PC;
        redir_mis = |bus.REDIRECT_PC[1:0];
`else
        redir_pc  = {bus.REDIRECT_PC[31:2], 2'b00};
`endif
    end

    always_comb begin
        state_d     = bus.FETCH_EN ? ST_RUN : ST_IDLE;
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        outst_d     = outst_q - OW'(ready_eff) + OW'(issue);
        discard_d   = discard_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
`ifdef FETCH_MISALIGN_EN
        fifo_mis_d  = fifo_mis_q;
        if (state_q == ST_FAULT) state_d = ST_FAULT;
`endif
        if (ready_eff && (discard_q != '0)) discard_d = discard_q - OW'(1);
        if (issue) fetch_pc_d = fetch_pc_q + 32'd4;

        if (bus.REDIRECT_VALID) begin
            // Everything still in flight after this cycle's retirement is stale
            state_d    = bus.FETCH_EN ? ST_RUN : ST_IDLE;
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            discard_d  = outst_q - OW'(ready_eff);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
`ifdef FETCH_MISALIGN_EN
            if (redir_mis) begin
                state_d        = ST_FAULT;
                fifo_data_d[0] = '0;
                fifo_pc_d[0]   = redir_pc;
                fifo_mis_d[0]  = 1'b1;
                wr_ptr_d       = AW'(1);
                count_d        = CW'(1);
            end
`endif
        end else begin
            if (push) begin
                fifo_data_d[wr_ptr_q] = bus.I_MEM_RDATA;
                fifo_pc_d[wr_ptr_q]   = resp_pc_q;
`ifdef FETCH_MISALIGN_EN
                fifo_mis_d[wr_ptr_q]  = 1'b0;
`endif
                wr_ptr_d  = wr_ptr_q + AW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= RESET_PC;
`ifdef FETCH_MISALIGN_EN
                fifo_mis_q[i]  <= 1'b0;
`endif
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            outst_q     <= outst_d;
            discard_q   <= discard_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
`ifdef FETCH_MISALIGN_EN
            fifo_mis_q  <= fifo_mis_d;
`endif
        end
    end

    assign bus.I_MEM_VALID = issue;
    assign bus.I_MEM_ADDR  = fetch_pc_q;
    assign bus.I_MEM_WSTB  = '0;
    assign bus.I_MEM_WDATA = '0;
    assign bus.INST_VALID  = (count_q != '0);
    assign bus.INST_DATA   = fifo_data_q[rd_ptr_q];
    assign bus.INST_PC     = fifo_pc_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_EN
    assign bus.INST_MISALIGN = fifo_mis_q[rd_ptr_q];
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle plus directed literal checks.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC(RST_PC),
        .FIFO_DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hA000_0000 | (a >> 2);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Memory: answers in request order one cycle after the request, unless held
    logic [31:0] pend[$];
    bit mem_hold = 0, inj_ready = 0, hold_c = 0, inj_c = 0;
    always @(negedge CLK) begin
        if (RST_N && bus.I_MEM_VALID) pend.push_back(bus.I_MEM_ADDR);
        hold_c = mem_hold;
        inj_c  = inj_ready;
    end
    always @(posedge CLK) begin
        #1;
        if (!RST_N) begin
            pend.delete();
            bus.I_MEM_READY = 1'b0;
        end else if (!hold_c && pend.size() != 0) begin
            bus.I_MEM_READY = 1'b1;
            bus.I_MEM_RDATA = memf(pend.pop_front());
        end else begin
            bus.I_MEM_READY = inj_c;
            bus.I_MEM_RDATA = 32'hDEAD_BEEF;
        end
    end

    // Reference model: decoded-instruction queue plus in-flight request list
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        mis;
    } ent_t;
    ent_t        mq[$];
    bit          fl[$];
    logic [31:0] m_addr, m_pc, tgt;
    bit          m_run, m_fault, exp_issue, got, s;

    always @(negedge CLK) begin
        if (!RST_N) begin
            mq.delete();
            fl.delete();
            m_addr  = RST_PC;
            m_pc    = RST_PC;
            m_run   = 0;
            m_fault = 0;
        end else begin
            exp_issue = m_run && !m_fault && !bus.REDIRECT_VALID && (fl.size() < MAXO)
                        && ((mq.size() + fl.size()) < DEPTH);
            chk("m_inst_valid", 32'(bus.INST_VALID), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("m_inst_pc", bus.INST_PC, mq[0].pc);
                chk("m_inst_data", bus.INST_DATA, mq[0].data);
`ifdef FETCH_MISALIGN_EN
                chk("m_inst_mis", 32'(bus.INST_MISALIGN), 32'(mq[0].mis));
`endif
            end
            chk("m_mem_valid", 32'(bus.I_MEM_VALID), 32'(exp_issue));
            if (exp_issue) chk("m_mem_addr", bus.I_MEM_ADDR, m_addr);
            chk("m_wstb", 32'(bus.I_MEM_WSTB), 32'd0);
            chk("m_wdata", bus.I_MEM_WDATA, 32'd0);

            got = 0;
            if (bus.I_MEM_READY && fl.size() != 0) begin
                s   = fl.pop_front();
                got = !s;
            end
            if (bus.REDIRECT_VALID) begin
                tgt = bus.REDIRECT_PC;
                mq.delete();
                foreach (fl[i]) fl[i] = 1;
`ifdef FETCH_MISALIGN_EN
                m_fault = (tgt[1:0] != 2'b00);
                if (m_fault) mq.push_back('{tgt, 32'd0, 1'b1});
`else
                tgt[1:0] = 2'b00;
`endif
                m_addr = tgt;
                m_pc   = tgt;
            end else begin
                if (mq.size() != 0 && bus.INST_READY) void'(mq.pop_front());
                if (got) begin
                    mq.push_back('{m_pc, memf(m_pc), 1'b0});
                    m_pc += 32'd4;
                end
            end
            if (exp_issue) begin
                fl.push_back(0);
                m_addr += 32'd4;
            end
            m_run = bus.FETCH_EN;
        end
    end

    task automatic wait_valid(input string nm);
        int n = 0;
        @(negedge CLK);
        while (!bus.INST_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, 32'(bus.INST_VALID), 32'd1);
    endtask

    initial begin
        RST_N = 1'b0;
        bus.FETCH_EN = 0; bus.REDIRECT_VALID = 0; bus.REDIRECT_PC = '0; bus.INST_READY = 0;
        bus.I_MEM_READY = 0; bus.I_MEM_RDATA = '0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_mem_valid", 32'(bus.I_MEM_VALID), 0);
        chk("rst_mem_addr", bus.I_MEM_ADDR, RST_PC);
        chk("rst_inst_valid", 32'(bus.INST_VALID), 0);
        chk("rst_inst_data", bus.INST_DATA, 0);
        chk("rst_inst_pc", bus.INST_PC, RST_PC);

        // T1: first word three cycles after enable, then one per cycle
        tick();
        bus.FETCH_EN = 1; bus.INST_READY = 1;
        @(negedge CLK) chk("t1_c0_valid", 32'(bus.INST_VALID), 0);
        tick();
        @(negedge CLK);
        chk("t1_c1_req", 32'(bus.I_MEM_VALID), 1);
        chk("t1_c1_addr", bus.I_MEM_ADDR, 32'h0);
        tick();
        @(negedge CLK) chk("t1_c2_valid", 32'(bus.INST_VALID), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge CLK);
            chk("t1_valid", 32'(bus.INST_VALID), 1);
            chk("t1_pc", bus.INST_PC, 32'(4 * i));
            chk("t1_data", bus.INST_DATA, 32'hA000_0000 + 32'(i));
        end

        // T2: decode stall fills the FIFO, then drains without a gap
        tick();
        bus.INST_READY = 0;
        repeat (10) tick();
        @(negedge CLK);
        chk("t2_no_req", 32'(bus.I_MEM_VALID), 0);
        chk("t2_valid", 32'(bus.INST_VALID), 1);
        chk("t2_head", bus.INST_PC, 32'h10);
        tick();
        bus.INST_READY = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("t2_drain_valid", 32'(bus.INST_VALID), 1);
            chk("t2_drain_pc", bus.INST_PC, 32'h10 + 32'(4 * i));
            tick();
        end

        // T3: redirect with two reads in flight
        mem_hold = 1;
        repeat (3) tick();
        bus.REDIRECT_VALID = 1; bus.REDIRECT_PC = 32'h100;
        tick();
        bus.REDIRECT_VALID = 0; mem_hold = 0;
        @(negedge CLK) chk("t3_flushed", 32'(bus.INST_VALID), 0);
        wait_valid("t3_timeout");
        chk("t3_pc", bus.INST_PC, 32'h100);
        chk("t3_data", bus.INST_DATA, 32'hA000_0040);

`ifdef FETCH_MISALIGN_EN
        // T6: misaligned redirect parks in FAULT until an aligned redirect
        tick();
        bus.INST_READY = 0; bus.REDIRECT_VALID = 1; bus.REDIRECT_PC = 32'h102;
        tick();
        bus.REDIRECT_VALID = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("t6_valid", 32'(bus.INST_VALID), 1);
            chk("t6_mis", 32'(bus.INST_MISALIGN), 1);
            chk("t6_pc", bus.INST_PC, 32'h102);
            chk("t6_data", bus.INST_DATA, 0);
            chk("t6_no_req", 32'(bus.I_MEM_VALID), 0);
            tick();
        end
        bus.REDIRECT_VALID = 1; bus.REDIRECT_PC = 32'h200; bus.INST_READY = 1;
        tick();
        bus.REDIRECT_VALID = 0;
        wait_valid("t6_timeout");
        chk("t6_pc2", bus.INST_PC, 32'h200);
        chk("t6_mis2", 32'(bus.INST_MISALIGN), 0);
        chk("t6_data2", bus.INST_DATA, 32'hA000_0080);
`else
        // Low address bits of a redirect target are dropped
        tick();
        bus.REDIRECT_VALID = 1; bus.REDIRECT_PC = 32'h202;
        tick();
        bus.REDIRECT_VALID = 0;
        wait_valid("mis_timeout");
        chk("mis_pc", bus.INST_PC, 32'h200);
        chk("mis_data", bus.INST_DATA, 32'hA000_0080);
`endif

        // T4: enable drops with reads in flight; stray READY afterwards is ignored
        tick();
        mem_hold = 1;
        repeat (3) tick();
        bus.FETCH_EN = 0; bus.INST_READY = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK) chk("t4_no_req", 32'(bus.I_MEM_VALID), 0);
            tick();
            mem_hold = 0;
        end
        @(negedge CLK) chk("t4_landed", 32'(bus.INST_VALID), 1);
        tick();
        inj_ready = 1;
        tick();
        inj_ready = 0;
        repeat (3) tick();
        bus.FETCH_EN = 1; bus.INST_READY = 1;
        repeat (10) tick();

        // T5: address wrap at the top of the space
        bus.FETCH_EN = 0;
        repeat (6) tick();
        bus.REDIRECT_VALID = 1; bus.REDIRECT_PC = 32'hFFFF_FFF8; bus.FETCH_EN = 1;
        tick();
        bus.REDIRECT_VALID = 0;
        @(negedge CLK) chk("t5_a0", bus.I_MEM_ADDR, 32'hFFFF_FFF8);
        tick();
        @(negedge CLK) chk("t5_a1", bus.I_MEM_ADDR, 32'hFFFF_FFFC);
        tick();
        @(negedge CLK);
        chk("t5_req", 32'(bus.I_MEM_VALID), 1);
        chk("t5_a2", bus.I_MEM_ADDR, 32'h0000_0000);
        repeat (6) tick();

        // Asynchronous reset mid-operation
        @(negedge CLK);
        #1 RST_N = 1'b0;
        #1;
        chk("arst_mem_valid", 32'(bus.I_MEM_VALID), 0);
        chk("arst_inst_valid", 32'(bus.INST_VALID), 0);
        chk("arst_mem_addr", bus.I_MEM_ADDR, RST_PC);
        chk("arst_inst_pc", bus.INST_PC, RST_PC);
        repeat (3) tick();
        RST_N = 1'b1;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
